// File: rtl/piso_pkg.sv
// piso_pkg -- shared definitions for the PISO round-robin scheduler.
//
// Contents:
//   state_t  : scheduler FSM states (idle/arbitrate, shift frame, forced gap)
//   PISO_W   : default word width
//   src_t    : requester index type (0 or 1)
//
// Optional feature macro used by piso_sched: PISO_PARITY_EN.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int PISO_W = 4;

  typedef logic src_t;

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg -- W-bit parallel-load / shift-left register with MSB output.
//
// Ports:
//   c    in   clock
//   r    in   asynchronous active-high reset (register cleared to 0)
//   en   in   synchronous enable for load or shift
//   m    in   mode: 0 = load d, 1 = shift toward MSB with zero fill
//   d    in   W-bit parallel load word
//   msb  out  current MSB of the register
module piso_shreg
  import piso_pkg::*;
#(
  parameter int W = PISO_W
) (
  input  logic         c,
  input  logic         r,
  input  logic         en,
  input  logic         m,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] sh_reg;

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      sh_reg <= '0;
    end else if (en) begin
      if (m) begin
        sh_reg <= {sh_reg[W-2:0], 1'b0};
      end else begin
        sh_reg <= d;
      end
    end
  end

  assign msb = sh_reg[W-1];

endmodule

// File: rtl/piso_sched.sv
// piso_sched -- round-robin scheduler sharing one PISO shift register
// between two valid/ready requesters. Each accepted word is sent MSB first
// as one frame with first/last/source markers.
//
// Parameters:
//   W    word width (2..16)
//   GAP  forced idle cycles after each frame (0..15)
//
// Ports:
//   c         in   clock
//   r         in   asynchronous active-high reset
//   v0, d0    in   requester 0 valid / word
//   rdy0      out  requester 0 accepted (combinational, IDLE only)
//   v1, d1    in   requester 1 valid / word
//   rdy1      out  requester 1 accepted (combinational, IDLE only)
//   so        out  serial data bit
//   so_v      out  so carries a frame bit
//   so_first  out  first bit of frame
//   so_last   out  last bit of frame
//   so_src    out  requester owning the current/last frame
//   busy      out  FSM not in IDLE
//
// Macro PISO_PARITY_EN: when defined, an even-parity bit (XOR of the
// accepted word) is appended after the LSB, making frames W+1 bits long.
module piso_sched
  import piso_pkg::*;
#(
  parameter int W   = PISO_W,
  parameter int GAP = 0
) (
  input  logic         c,
  input  logic         r,
  input  logic         v0,
  input  logic [W-1:0] d0,
  output logic         rdy0,
  input  logic         v1,
  input  logic [W-1:0] d1,
  output logic         rdy1,
  output logic         so,
  output logic         so_v,
  output logic         so_first,
  output logic         so_last,
  output logic         so_src,
  output logic         busy
);

`ifdef PISO_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  // Counter index of the final frame bit, and of the final gap cycle.
  localparam logic [4:0] BIT_LAST = 5'(L - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  state_t       state_reg;
  src_t         ptr_reg;
  src_t         src_reg;
  logic [4:0]   bit_cnt_reg;
  logic [3:0]   gap_cnt_reg;

  logic         any_valid;
  src_t         grant_idx;
  logic [W-1:0] grant_word;
  logic         in_idle;
  logic         in_shift;
  logic         transfer;
  logic         sh_en;
  logic         sh_msb;

  // Round-robin arbitration: on contention the pointer wins, otherwise the
  // single valid requester is granted.
  always_comb begin
    any_valid = v0 | v1;
    if (v0 & v1) begin
      grant_idx = ptr_reg;
    end else if (v1) begin
      grant_idx = 1'b1;
    end else begin
      grant_idx = 1'b0;
    end
    grant_word = grant_idx ? d1 : d0;
  end

  assign in_idle  = (state_reg == ST_IDLE);
  assign in_shift = (state_reg == ST_SHIFT);
  assign transfer = in_idle & any_valid;

  // Gated with r so that no handshake completes while reset is held.
  assign rdy0 = transfer & ~r & (grant_idx == 1'b0);
  assign rdy1 = transfer & ~r & (grant_idx == 1'b1);

  // Load on the accepting edge, shift on every SHIFT cycle.
  assign sh_en = transfer | in_shift;

  piso_shreg #(
    .W(W)
  ) u_shreg (
    .c  (c),
    .r  (r),
    .en (sh_en),
    .m  (in_shift),
    .d  (grant_word),
    .msb(sh_msb)
  );

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= 1'b0;
      src_reg     <= 1'b0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (transfer) begin
            src_reg     <= grant_idx;
            ptr_reg     <= ~grant_idx;
            bit_cnt_reg <= '0;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            state_reg   <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  logic parity_reg;

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      parity_reg <= 1'b0;
    end else if (transfer) begin
      parity_reg <= ^grant_word;
    end
  end

  // The extra final bit comes from the parity flop; the shift register is
  // already drained to zero by then.
  assign so = in_shift & ((bit_cnt_reg == BIT_LAST) ? parity_reg : sh_msb);
`else
  assign so = in_shift & sh_msb;
`endif

  assign so_v     = in_shift;
  assign so_first = in_shift & (bit_cnt_reg == 5'd0);
  assign so_last  = in_shift & (bit_cnt_reg == BIT_LAST);
  assign so_src   = src_reg;
  assign busy     = ~in_idle;

endmodule

// File: tb/tb_piso_sched.sv
// tb_piso_sched -- self-checking bench for piso_sched (W=4).
// dut0 uses GAP=0 and is checked by a cycle model plus bit scoreboard;
// dut2 uses GAP=2 and is checked for accept spacing and idle gaps.
module tb_piso_sched;

`ifdef PISO_PARITY_EN
  localparam int L_EXP = 5;
  localparam bit PAR = 1'b1;
`else
  localparam int L_EXP = 4;
  localparam bit PAR = 1'b0;
`endif

  logic c = 1'b0;
  logic r;
  logic v0, v1;
  logic [3:0] d0, d1;
  logic rdy0, rdy1, so, so_v, so_first, so_last, so_src, busy;

  logic v0b, v1b;
  logic [3:0] d0b, d1b;
  logic rdy0b, rdy1b, so_b, so_vb, so_first_b, so_last_b, so_src_b, busy_b;

  always #5 c = ~c;

  piso_sched #(.W(4), .GAP(0)) dut0 (
    .c(c), .r(r), .v0(v0), .d0(d0), .rdy0(rdy0), .v1(v1), .d1(d1), .rdy1(rdy1),
    .so(so), .so_v(so_v), .so_first(so_first), .so_last(so_last),
    .so_src(so_src), .busy(busy)
  );

  piso_sched #(.W(4), .GAP(2)) dut2 (
    .c(c), .r(r), .v0(v0b), .d0(d0b), .rdy0(rdy0b), .v1(v1b), .d1(d1b), .rdy1(rdy1b),
    .so(so_b), .so_v(so_vb), .so_first(so_first_b), .so_last(so_last_b),
    .so_src(so_src_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard for dut0 ----------------
  typedef struct packed {
    logic b;
    logic first;
    logic last;
    logic src;
  } bit_t;

  bit_t sb_q[$];

  task automatic push_frame(input logic [3:0] w, input logic s);
    bit_t e;
    for (int i = 0; i < L_EXP; i++) begin
      e.b     = (i < 4) ? w[3-i] : ^w;
      e.first = (i == 0);
      e.last  = (i == L_EXP - 1);
      e.src   = s;
      sb_q.push_back(e);
    end
  endtask

  int   m_rem = 0;
  logic m_ptr = 1'b0;
  logic eg0, eg1;

  always @(negedge c) begin
    if (r) begin
      sb_q.delete();
      m_rem = 0;
      m_ptr = 1'b0;
    end else begin
      eg0 = (m_rem == 0) && v0 && (!v1 || m_ptr == 1'b0);
      eg1 = (m_rem == 0) && v1 && (!v0 || m_ptr == 1'b1);
      chk("rdy0", int'(rdy0), int'(eg0));
      chk("rdy1", int'(rdy1), int'(eg1));
      chk("busy", int'(busy), int'(m_rem != 0));
      chk("so_v", int'(so_v), int'(m_rem > 0));
      if (so_v) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_bit", 1, 0);
        end else begin
          bit_t e;
          e = sb_q.pop_front();
          chk("so", int'(so), int'(e.b));
          chk("so_first", int'(so_first), int'(e.first));
          chk("so_last", int'(so_last), int'(e.last));
          chk("so_src", int'(so_src), int'(e.src));
        end
      end else begin
        chk("idle_outs", int'({so, so_first, so_last}), 0);
      end
      if (eg0 || eg1) begin
        push_frame(eg0 ? d0 : d1, eg1);
        m_rem = L_EXP;
        m_ptr = eg0;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
  end

  // ---------------- dut2 (GAP=2) monitor ----------------
  logic en2 = 1'b0;
  int   acc2 = 0;
  int   prev2 = 0;
  int   low_run = 0;
  logic seen2 = 1'b0;

  always @(negedge c) begin
    if (!r) begin
      chk("g_rdy1", int'(rdy1b), 0);
      if (so_vb) begin
        chk("g_src", int'(so_src_b), 0);
        chk("g_busy", int'(busy_b), 1);
      end else begin
        chk("g_idle_outs", int'({so_b, so_first_b, so_last_b}), 0);
      end
      if (en2) begin
        if (v0b && rdy0b) begin
          if (acc2 > 0) chk("gap_period", cyc - prev2, L_EXP + 3);
          prev2 = cyc;
          acc2++;
        end
        if (so_vb) begin
          if (seen2 && low_run > 0) chk("gap_idle_run", low_run, 3);
          seen2   = 1'b1;
          low_run = 0;
        end else if (seen2) begin
          low_run++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic       v0, v1;
    logic [3:0] d0, d1;
    logic       rdy0, rdy1;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge c);
      #1;
      if (!busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int   n;
    int   prev;
    logic exp_src;
    logic found;

    // Pointer starts at 0; each row's expected grant follows from the
    // rotation left by the rows before it.
    vecs[0] = '{1'b1, 1'b0, 4'b1101, 4'h0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'h3,    4'hC, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 4'h0,    4'b1001, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 4'b1001, 4'h6, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 4'b0111, 4'h0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 4'h8,    4'hE, 1'b0, 1'b1};

    r = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'hF; d1 = 4'hF;
    v0b = 1'b0; v1b = 1'b0; d0b = 4'h0; d1b = 4'h0;

    repeat (2) @(posedge c);
    @(negedge c);
    chk("rst_outs", int'({so, so_v, so_first, so_last, so_src, busy}), 0);
    chk("rst_rdy", int'({rdy0, rdy1}), 0);
    chk("rst_outs_b", int'({so_b, so_vb, so_first_b, so_last_b, so_src_b, busy_b}), 0);
    @(posedge c);
    #1;
    r = 1'b0; v0 = 1'b0; v1 = 1'b0;

    // Table-driven arbitration and frame contents.
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      v0 = vecs[i].v0; v1 = vecs[i].v1; d0 = vecs[i].d0; d1 = vecs[i].d1;
      @(negedge c);
      chk($sformatf("vec%0d_rdy0", i), int'(rdy0), int'(vecs[i].rdy0));
      chk($sformatf("vec%0d_rdy1", i), int'(rdy1), int'(vecs[i].rdy1));
      @(posedge c);
      #1;
      v0 = 1'b0; v1 = 1'b0;
    end

    // Both requesters valid continuously: alternating frames, fixed period.
    wait_idle();
    v0 = 1'b1; v1 = 1'b1; d0 = 4'hA; d1 = 4'h5;
    n = 0; prev = 0; exp_src = 1'b0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge c);
      if (rdy0 || rdy1) begin
        chk("cont_src", int'(rdy1), int'(exp_src));
        exp_src = ~exp_src;
        if (n > 0) chk("cont_period", cyc - prev, L_EXP + 1);
        prev = cyc;
        n++;
      end
    end
    chk("cont_count", n, 4);
    @(posedge c);
    #1;
    v0 = 1'b0; v1 = 1'b0;

    // v1 raised mid-frame of a req0 frame.
    wait_idle();
    v0 = 1'b1; d0 = 4'b0110;
    @(posedge c);
    #1;
    v0 = 1'b0;
    repeat (2) @(posedge c);
    #1;
    v1 = 1'b1; d1 = 4'b1011;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge c);
      if (busy) begin
        chk("mid_rdy1_busy", int'(rdy1), 0);
      end else begin
        chk("mid_rdy1_idle", int'(rdy1), 1);
        found = 1'b1;
      end
    end
    if (!found) chk("mid_timeout", 0, 1);
    @(posedge c);
    #1;
    v1 = 1'b0;

    // Reset during bit 2 of a frame; pointer returns to requester 0.
    wait_idle();
    v0 = 1'b1; d0 = 4'hF;
    @(posedge c);
    #1;
    v0 = 1'b0;
    repeat (2) @(posedge c);
    #1;
    r = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'h9; d1 = 4'h6;
    @(negedge c);
    chk("mrst_so_v", int'(so_v), 0);
    chk("mrst_so_last", int'(so_last), 0);
    chk("mrst_outs", int'({so, so_first, so_src, busy}), 0);
    chk("mrst_rdy", int'({rdy0, rdy1}), 0);
    @(posedge c);
    #1;
    r = 1'b0;
    @(negedge c);
    chk("mrst_grant0", int'(rdy0), 1);
    chk("mrst_grant1", int'(rdy1), 0);
    @(posedge c);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // GAP=2 instance with requester 0 held valid.
    en2 = 1'b1; v0b = 1'b1; d0b = 4'h9;
    repeat (45) @(posedge c);
    #1;
    v0b = 1'b0; en2 = 1'b0;
    chk("gap_accepts_ok", int'(acc2 >= 5), 1);

    repeat (12) @(posedge c);
    #1;
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
